// File: rtl/ISO14443A_pkg.sv
// rtl/ISO14443A_pkg.sv - shared ISO14443A byte/data_bits encoding and frame buffer states
package ISO14443A_pkg;

  localparam int BYTE_W      = 8;
  localparam int DATA_BITS_W = 3;
  // data_bits of zero encodes a full 8-bit byte
  localparam logic [DATA_BITS_W-1:0] DATA_BITS_FULL = '0;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVING,
    DISCARD,
    SENDING
  } frame_buffer_state_t;

  function automatic logic is_partial(input logic [DATA_BITS_W-1:0] bits);
    return bits != DATA_BITS_FULL;
  endfunction

endpackage

// File: rtl/frame_byte_ram.sv
// rtl/frame_byte_ram.sv - DEPTHx8 frame store, one write port, one registered read port
module frame_byte_ram
  import ISO14443A_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first bypass: a one-byte frame is stored and read back on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/rx_tx_frame_buffer.sv
// rtl/rx_tx_frame_buffer.sv - captures one rx frame, drops it on error/overflow, replays it to tx
module rx_tx_frame_buffer
  import ISO14443A_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_soc,
  input  logic                   rx_eoc,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic [DATA_BITS_W-1:0] rx_data_bits,
  input  logic                   rx_data_valid,
  input  logic                   rx_error,
  output logic [BYTE_W-1:0]      tx_data,
  output logic [DATA_BITS_W-1:0] tx_data_bits,
  output logic                   tx_ready_to_send,
  input  logic                   tx_req,
  output logic                   frame_dropped
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  frame_buffer_state_t state, state_d;
  logic [CNT_W-1:0]       wr_cnt, wr_cnt_d;
  logic [CNT_W-1:0]       rd_cnt, rd_cnt_d;
  logic [DATA_BITS_W-1:0] last_bits, last_bits_d;
  logic [DATA_BITS_W-1:0] bits_d;
  logic                   ready_d;
  logic                   dropped_d;
  logic                   mem_we;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;

  frame_byte_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_frame_byte_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(wr_cnt[ADDR_W-1:0]),
    .wdata(rx_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(tx_data)
  );

  always_comb begin
    state_d     = state;
    wr_cnt_d    = wr_cnt;
    rd_cnt_d    = rd_cnt;
    last_bits_d = last_bits;
    bits_d      = tx_data_bits;
    ready_d     = tx_ready_to_send;
    dropped_d   = 1'b0;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    case (state)
      IDLE: begin
        if (rx_soc) begin
          state_d     = RECEIVING;
          wr_cnt_d    = '0;
          last_bits_d = DATA_BITS_FULL;
        end
      end
      RECEIVING: begin
        if (rx_error) begin
          dropped_d = 1'b1;
          state_d   = rx_eoc ? IDLE : DISCARD;
        end else if (rx_soc) begin
          wr_cnt_d    = '0;
          last_bits_d = DATA_BITS_FULL;
        end else if (rx_data_valid && (wr_cnt == CNT_FULL || is_partial(last_bits))) begin
          dropped_d = 1'b1;
          state_d   = rx_eoc ? IDLE : DISCARD;
        end else begin
          if (rx_data_valid) begin
            mem_we      = 1'b1;
            wr_cnt_d    = wr_cnt + CNT_ONE;
            last_bits_d = rx_data_bits;
          end
          // Commit sees the byte stored on this same edge
          if (rx_eoc) begin
            if (wr_cnt_d != '0) begin
              state_d  = SENDING;
              rd_cnt_d = '0;
              rd_en    = 1'b1;
              ready_d  = 1'b1;
              bits_d   = (wr_cnt_d > CNT_ONE) ? DATA_BITS_FULL : last_bits_d;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DISCARD: begin
        if (rx_soc) begin
          state_d     = RECEIVING;
          wr_cnt_d    = '0;
          last_bits_d = DATA_BITS_FULL;
        end else if (rx_eoc) begin
          state_d = IDLE;
        end
      end
      SENDING: begin
        if (rx_soc) begin
          state_d     = RECEIVING;
          ready_d     = 1'b0;
          wr_cnt_d    = '0;
          last_bits_d = DATA_BITS_FULL;
        end else if (tx_req) begin
          if (rd_cnt + CNT_ONE < wr_cnt) begin
            rd_cnt_d = rd_cnt + CNT_ONE;
            rd_en    = 1'b1;
            rd_addr  = rd_cnt_d[ADDR_W-1:0];
            bits_d   = (rd_cnt_d + CNT_ONE < wr_cnt) ? DATA_BITS_FULL : last_bits;
          end else begin
            ready_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
      last_bits        <= DATA_BITS_FULL;
      tx_data_bits     <= DATA_BITS_FULL;
      tx_ready_to_send <= 1'b0;
      frame_dropped    <= 1'b0;
    end else begin
      state            <= state_d;
      wr_cnt           <= wr_cnt_d;
      rd_cnt           <= rd_cnt_d;
      last_bits        <= last_bits_d;
      tx_data_bits     <= bits_d;
      tx_ready_to_send <= ready_d;
      frame_dropped    <= dropped_d;
    end
  end

endmodule
